// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising checker for the b[n] = b[n-7] ^ b[n-8] PRBS stream
// Hunts for lock on received bits, then free-runs a local reference and counts bit errors.
module prbs_checker #(
  parameter int LOCK_CNT  = 16,
  parameter int WINDOW    = 32,
  parameter int LOSS_ERRS = 4,
  parameter int ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {S_HUNT, S_LOCKED} state_t;

  localparam logic [7:0]       LOCK_C   = 8'(LOCK_CNT);
  localparam logic [7:0]       WIN_LAST = 8'(WINDOW - 1);
  localparam logic [8:0]       LOSS_C   = 9'(LOSS_ERRS);
  localparam logic [ERR_W-1:0] CNT_ONE  = ERR_W'(1);

  state_t     state;
  logic [7:0] sr;
  logic [3:0] fill;
  logic [7:0] match;
  logic [7:0] win;
  logic [7:0] werr;

  logic       pred;
  logic       mismatch;
  logic [7:0] match_next;
  logic [8:0] werr_next;
  logic       loss_hit;
  logic       err_sat;

  always_comb begin
    pred       = sr[6] ^ sr[7];
    mismatch   = din ^ pred;
    // An all-zero history trivially predicts zero, so it must never count toward lock.
    match_next = (!mismatch && (sr != 8'd0)) ? (match + 8'd1) : 8'd0;
    werr_next  = {1'b0, werr} + {8'd0, mismatch};
    loss_hit   = (LOSS_ERRS != 0) && (werr_next == LOSS_C);
    err_sat    = &err_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_HUNT;
      sr        <= 8'd0;
      fill      <= 4'd0;
      match     <= 8'd0;
      win       <= 8'd0;
      werr      <= 8'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (din_valid) begin
        case (state)
          S_HUNT: begin
            sr <= {sr[6:0], din};
            if (fill != 4'd8) begin
              fill <= fill + 4'd1;
            end else if (match_next == LOCK_C) begin
              state  <= S_LOCKED;
              locked <= 1'b1;
              match  <= 8'd0;
              win    <= 8'd0;
              werr   <= 8'd0;
            end else begin
              match <= match_next;
            end
          end
          S_LOCKED: begin
            // Shift the prediction, not din, so a bad bit cannot corrupt later predictions.
            sr        <= {sr[6:0], pred};
            err_pulse <= mismatch;
            if (mismatch && !err_sat)
              err_cnt <= err_cnt + CNT_ONE;
            if (loss_hit) begin
              state  <= S_HUNT;
              locked <= 1'b0;
              fill   <= 4'd0;
              match  <= 8'd0;
            end else if (win == WIN_LAST) begin
              win  <= 8'd0;
              werr <= 8'd0;
            end else begin
              win  <= win + 8'd1;
              werr <= werr_next[7:0];
            end
          end
        endcase
      end
      // Written last so a clear wins over a same-cycle increment.
      if (clr_cnt)
        err_cnt <= '0;
    end
  end

endmodule
